// File: rtl/ex_mul_unit.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit consuming STEP_BITS multiplier bits per cycle.
// Long 64-bit forms are built only when EX_MUL_LONG_EN is defined; otherwise P is DATA_W wide.
module ex_mul_unit #(
    parameter int DATA_W     = 32,
    parameter int STEP_BITS  = 8,
    parameter int EARLY_TERM = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_op_rm,
    input  logic [DATA_W-1:0] i_op_rs,
    input  logic [DATA_W-1:0] i_acc_lo,
    input  logic [DATA_W-1:0] i_acc_hi,
    input  logic              i_accumulate,
    input  logic              i_long,
    input  logic              i_signed,
    input  logic              i_set_flags,
    input  logic [3:0]        i_nzcv,
    input  logic [3:0]        i_rd_lo_code,
    input  logic [3:0]        i_rd_hi_code,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result_lo,
    output logic [DATA_W-1:0] o_result_hi,
    output logic              o_rd_lo_en,
    output logic              o_rd_hi_en,
    output logic [3:0]        o_rd_lo_code,
    output logic [3:0]        o_rd_hi_code,
    output logic              o_nzcv_en,
    output logic [3:0]        o_nzcv
);

`ifdef EX_MUL_LONG_EN
    localparam int PW = 2 * DATA_W;
`else
    localparam int PW = DATA_W;
`endif
    localparam int N  = DATA_W / STEP_BITS;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic [PW-1:0]     p_q;
    logic [PW-1:0]     mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [KW-1:0]     k_q;
    logic              signed_q;
    logic              set_flags_q;
    logic [1:0]        cv_q;
    logic [3:0]        cap_lo_code_q;

    logic              done_q;
    logic [DATA_W-1:0] res_lo_q;
    logic              lo_en_q;
    logic [3:0]        lo_code_q;
    logic              nzcv_en_q;
    logic [3:0]        nzcv_q;

`ifdef EX_MUL_LONG_EN
    logic              long_q;
    logic [3:0]        cap_hi_code_q;
    logic [DATA_W-1:0] res_hi_q;
    logic              hi_en_q;
    logic [3:0]        hi_code_q;
`endif

    logic [STEP_BITS-1:0]   chunk;
    logic [DATA_W-STEP_BITS:0] upper;
    logic                   early_d;
    logic                   last_d;
    logic                   chunk_neg;
    logic [PW-1:0]          chunk_ext;
    logic [PW-1:0]          pp;
    logic [PW-1:0]          p_d;
    logic [PW-1:0]          mcand_init;
    logic [PW-1:0]          acc_init;
    logic                   n_d;
    logic                   z_d;

    always_comb begin
        chunk = mplier_q[STEP_BITS-1:0];
        // Remaining multiplier bits including the current chunk's MSB; the shift fill
        // keeps the sign (or zero) above, so this test is valid at every step.
        upper   = mplier_q[DATA_W-1:STEP_BITS-1];
        early_d = signed_q ? ((&upper) | ~(|upper)) : ~(|upper[DATA_W-STEP_BITS:1]);
        last_d  = (k_q == KW'(N - 1)) || ((EARLY_TERM != 0) && early_d);
        // The final chunk carries the negative weight of a signed multiplier.
        chunk_neg = signed_q & last_d & chunk[STEP_BITS-1];
        chunk_ext = {{(PW-STEP_BITS){chunk_neg}}, chunk};
        pp        = mcand_q * chunk_ext;
        p_d       = p_q + pp;
`ifdef EX_MUL_LONG_EN
        n_d        = long_q ? p_d[PW-1] : p_d[DATA_W-1];
        z_d        = long_q ? (p_d == '0) : (p_d[DATA_W-1:0] == '0);
        mcand_init = {{DATA_W{i_signed & i_op_rm[DATA_W-1]}}, i_op_rm};
        acc_init   = i_accumulate ? {i_acc_hi, i_acc_lo} : '0;
`else
        n_d        = p_d[DATA_W-1];
        z_d        = (p_d == '0);
        mcand_init = i_op_rm;
        acc_init   = i_accumulate ? i_acc_lo : '0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            p_q           <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            k_q           <= '0;
            signed_q      <= 1'b0;
            set_flags_q   <= 1'b0;
            cv_q          <= 2'b00;
            cap_lo_code_q <= 4'h0;
            done_q        <= 1'b0;
            res_lo_q      <= '0;
            lo_en_q       <= 1'b0;
            lo_code_q     <= 4'h0;
            nzcv_en_q     <= 1'b0;
            nzcv_q        <= 4'h0;
`ifdef EX_MUL_LONG_EN
            long_q        <= 1'b0;
            cap_hi_code_q <= 4'h0;
            res_hi_q      <= '0;
            hi_en_q       <= 1'b0;
            hi_code_q     <= 4'h0;
`endif
        end else begin
            done_q    <= 1'b0;
            res_lo_q  <= '0;
            lo_en_q   <= 1'b0;
            lo_code_q <= 4'h0;
            nzcv_en_q <= 1'b0;
            nzcv_q    <= 4'h0;
`ifdef EX_MUL_LONG_EN
            res_hi_q  <= '0;
            hi_en_q   <= 1'b0;
            hi_code_q <= 4'h0;
`endif
            case (state_q)
                IDLE: begin
                    if (i_start && !i_flush) begin
                        state_q       <= BUSY;
                        p_q           <= acc_init;
                        mcand_q       <= mcand_init;
                        mplier_q      <= i_op_rs;
                        k_q           <= '0;
                        signed_q      <= i_signed;
                        set_flags_q   <= i_set_flags;
                        cv_q          <= i_nzcv[1:0];
                        cap_lo_code_q <= i_rd_lo_code;
`ifdef EX_MUL_LONG_EN
                        long_q        <= i_long;
                        cap_hi_code_q <= i_rd_hi_code;
`endif
                    end
                end
                BUSY: begin
                    if (i_flush) begin
                        state_q <= IDLE;
                    end else begin
                        p_q      <= p_d;
                        mcand_q  <= mcand_q << STEP_BITS;
                        mplier_q <= {{STEP_BITS{signed_q & mplier_q[DATA_W-1]}},
                                     mplier_q[DATA_W-1:STEP_BITS]};
                        k_q      <= k_q + 1'b1;
                        if (last_d) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            res_lo_q  <= p_d[DATA_W-1:0];
                            lo_en_q   <= 1'b1;
                            lo_code_q <= cap_lo_code_q;
                            nzcv_en_q <= set_flags_q;
                            nzcv_q    <= set_flags_q ? {n_d, z_d, cv_q} : 4'h0;
`ifdef EX_MUL_LONG_EN
                            if (long_q) begin
                                res_hi_q  <= p_d[PW-1:DATA_W];
                                hi_en_q   <= 1'b1;
                                hi_code_q <= cap_hi_code_q;
                            end
`endif
                        end
                    end
                end
                // i_start is still the finished instruction here, so it is not re-sampled.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy       = ((state_q == IDLE) && i_start && !i_flush) || (state_q == BUSY);
    assign o_done       = done_q;
    assign o_result_lo  = res_lo_q;
    assign o_rd_lo_en   = lo_en_q;
    assign o_rd_lo_code = lo_code_q;
    assign o_nzcv_en    = nzcv_en_q;
    assign o_nzcv       = nzcv_q;

`ifdef EX_MUL_LONG_EN
    assign o_result_hi  = res_hi_q;
    assign o_rd_hi_en   = hi_en_q;
    assign o_rd_hi_code = hi_code_q;
`else
    assign o_result_hi  = '0;
    assign o_rd_hi_en   = 1'b0;
    assign o_rd_hi_code = 4'h0;

    logic unused_long_inputs;
    assign unused_long_inputs = ^{i_long, i_acc_hi, i_rd_hi_code};
`endif

    logic unused_nz_flags;
    assign unused_nz_flags = ^i_nzcv[3:2];

endmodule

// File: tb/tb_ex_mul_unit.sv
// Scoreboard bench for ex_mul_unit: one instance without and one with early termination.
`timescale 1ns/1ps
module tb_ex_mul_unit;
`ifdef EX_MUL_LONG_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start [2];
    logic        flush;
    logic [31:0] rm, rs, alo, ahi;
    logic        acc, lng, sgn, sflag;
    logic [3:0]  nz, clo, chi;

    logic        busy [2], done [2], lo_en [2], hi_en [2], nz_en [2];
    logic [31:0] res_lo [2], res_hi [2];
    logic [3:0]  lo_code [2], hi_code [2], nzo [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ex_mul_unit #(.DATA_W(32), .STEP_BITS(8), .EARLY_TERM(gi)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_start(start[gi]), .i_flush(flush),
            .i_op_rm(rm), .i_op_rs(rs), .i_acc_lo(alo), .i_acc_hi(ahi),
            .i_accumulate(acc), .i_long(lng), .i_signed(sgn), .i_set_flags(sflag),
            .i_nzcv(nz), .i_rd_lo_code(clo), .i_rd_hi_code(chi),
            .o_busy(busy[gi]), .o_done(done[gi]),
            .o_result_lo(res_lo[gi]), .o_result_hi(res_hi[gi]),
            .o_rd_lo_en(lo_en[gi]), .o_rd_hi_en(hi_en[gi]),
            .o_rd_lo_code(lo_code[gi]), .o_rd_hi_code(hi_code[gi]),
            .o_nzcv_en(nz_en[gi]), .o_nzcv(nzo[gi])
        );
    end

    typedef struct {
        int sel; logic [31:0] rm, rs, alo, ahi; logic acc, lng, sgn, s; logic [3:0] nz;
        logic [31:0] elo, ehi; logic [3:0] enz_l, enz_s; int lat;
    } vec_t;
    typedef struct {
        int sel; logic [31:0] lo, hi; logic hi_en, nz_en; logic [3:0] nz, clo, chi; int t0, lat;
    } exp_t;

    vec_t vq [$];
    exp_t sb [$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic addv(input int sel, input logic [31:0] a, b, al, ah, input logic ac, lg, sg, s,
                        input logic [3:0] n, input logic [31:0] elo, ehi,
                        input logic [3:0] enzl, enzs, input int lat);
        vec_t v;
        v.sel = sel; v.rm = a; v.rs = b; v.alo = al; v.ahi = ah; v.acc = ac; v.lng = lg;
        v.sgn = sg; v.s = s; v.nz = n; v.elo = elo; v.ehi = ehi; v.enz_l = enzl;
        v.enz_s = enzs; v.lat = lat;
        vq.push_back(v);
    endtask

    task automatic set_ops(input vec_t v, input logic [3:0] code);
        rm = v.rm; rs = v.rs; alo = v.alo; ahi = v.ahi; acc = v.acc; lng = v.lng;
        sgn = v.sgn; sflag = v.s; nz = v.nz; clo = code; chi = ~code;
    endtask

    // Called at a falling edge; presents the instruction and holds it until done.
    task automatic issue(input vec_t v, input logic [3:0] code);
        exp_t e;
        int   nb;
        bit   seen;
        set_ops(v, code);
        e.sel = v.sel; e.lo = v.elo; e.nz_en = v.s; e.clo = code; e.chi = ~code;
        e.t0 = cyc; e.lat = v.lat;
        if (LONG_EN && v.lng) begin
            e.hi = v.ehi; e.hi_en = 1'b1; e.nz = v.enz_l;
        end else begin
            e.hi = 32'h0; e.hi_en = 1'b0; e.nz = v.enz_s;
        end
        sb.push_back(e);
        start[v.sel] = 1'b1;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (busy[v.sel]) nb++;
            if (done[v.sel]) seen = 1'b1;
            @(negedge clk);
        end
        start[v.sel] = 1'b0;
        if (!seen) begin
            checks++; fails++;
            $display("FAIL done_timeout: dut%0d got no o_done within 40 cycles", v.sel);
        end
        chk("busy_cycles", 64'(nb), 64'(v.lat));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic quiet;
        if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
                if (done[s]) begin
                    if (sb.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_done: dut%0d lo=%08h with nothing pending", s, res_lo[s]);
                    end else begin
                        e = sb.pop_front();
                        chk("dut_sel", 64'(s), 64'(e.sel));
                        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                        chk("result_lo", 64'(res_lo[s]), 64'(e.lo));
                        chk("result_hi", 64'(res_hi[s]), 64'(e.hi));
                        chk("rd_lo_en", 64'(lo_en[s]), 64'd1);
                        chk("rd_hi_en", 64'(hi_en[s]), 64'(e.hi_en));
                        chk("rd_lo_code", 64'(lo_code[s]), 64'(e.clo));
                        if (e.hi_en) chk("rd_hi_code", 64'(hi_code[s]), 64'(e.chi));
                        chk("nzcv_en", 64'(nz_en[s]), 64'(e.nz_en));
                        if (e.nz_en) chk("nzcv", 64'(nzo[s]), 64'(e.nz));
                        $display("txn dut%0d hi=%08h lo=%08h nzcv_en=%0b nzcv=%04b latency=%0d",
                                 s, res_hi[s], res_lo[s], nz_en[s], nzo[s], cyc - e.t0);
                    end
                end else begin
                    quiet = |{res_lo[s], res_hi[s], lo_en[s], hi_en[s], nz_en[s], nzo[s],
                              lo_code[s], hi_code[s]};
                    chk("outputs_zero_without_done", 64'(quiet), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        vec_t v;
        int   dn;
        bit   seen;
        start[0] = 1'b0; start[1] = 1'b0; flush = 1'b0;
        rm = '0; rs = '0; alo = '0; ahi = '0; acc = 1'b0; lng = 1'b0; sgn = 1'b0;
        sflag = 1'b0; nz = 4'h0; clo = 4'h0; chi = 4'h0;

        //    sel rm            rs            alo     ahi  acc lng sgn S  nz      elo           ehi           enz_l   enz_s   lat
        addv(0, 32'd7,        32'd6,        32'd0,  32'd0, 0, 0, 0, 0, 4'b0000, 32'd42,       32'h0,        4'b0000, 4'b0000, 5);
        addv(0, 32'hFFFFFFFF, 32'd2,        32'd5,  32'd0, 1, 0, 0, 1, 4'b0011, 32'h00000003, 32'h0,        4'b0011, 4'b0011, 5);
        addv(0, 32'd0,        32'd2,        32'd0,  32'd0, 1, 0, 0, 1, 4'b0011, 32'h0,        32'h0,        4'b0111, 4'b0111, 5);
        addv(0, 32'hFFFFFFFD, 32'd5,        32'd0,  32'd0, 0, 1, 1, 1, 4'b0000, 32'hFFFFFFF1, 32'hFFFFFFFF, 4'b1000, 4'b1000, 5);
        addv(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,  32'd0, 1, 1, 0, 1, 4'b0000, 32'h00000002, 32'hFFFFFFFE, 4'b1000, 4'b0000, 5);
        addv(1, 32'd3,        32'h000000FF, 32'd0,  32'd0, 0, 0, 0, 0, 4'b0000, 32'h000002FD, 32'h0,        4'b0000, 4'b0000, 2);
        addv(1, 32'd5,        32'hFFFFFF80, 32'd0,  32'd0, 0, 1, 1, 0, 4'b0000, 32'hFFFFFD80, 32'hFFFFFFFF, 4'b0000, 4'b0000, 2);
        addv(1, 32'h00010000, 32'h00010000, 32'd0,  32'd0, 0, 1, 0, 1, 4'b0000, 32'h0,        32'h1,        4'b0000, 4'b0100, 4);
        addv(1, 32'd123,      32'd0,        32'd0,  32'd0, 0, 1, 1, 1, 4'b0000, 32'h0,        32'h0,        4'b0100, 4'b0100, 2);
        addv(1, 32'd3,        32'h80000000, 32'd0,  32'd0, 0, 1, 0, 0, 4'b0000, 32'h80000000, 32'h1,        4'b0000, 4'b0000, 5);
        addv(1, 32'd7,        32'd6,        32'd0,  32'd0, 0, 0, 0, 0, 4'b0000, 32'd42,       32'h0,        4'b0000, 4'b0000, 2);
        addv(1, 32'hFFFFFFFF, 32'd2,        32'd5,  32'd0, 1, 1, 1, 1, 4'b0010, 32'h00000003, 32'h0,        4'b0010, 4'b0010, 2);

        // Reset state; o_busy follows i_start while held in reset.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_busy", 64'(busy[s]), 64'd0);
            chk("reset_done", 64'(done[s]), 64'd0);
            chk("reset_result_lo", 64'(res_lo[s]), 64'd0);
        end
        start[1] = 1'b1;
        #1 chk("reset_busy_follows_start", 64'(busy[1]), 64'd1);
        start[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) issue(vq[i], 4'(i + 1));

        // Flush wins over start in IDLE.
        start[1] = 1'b1; flush = 1'b1;
        #1 chk("flush_over_start_busy", 64'(busy[1]), 64'd0);
        @(negedge clk);
        start[1] = 1'b0; flush = 1'b0;
        #1 chk("flush_over_start_idle", 64'(busy[1]), 64'd0);

        // Flush during the second BUSY cycle.
        v = vq[0];
        set_ops(v, 4'h3);
        start[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("flush_busy_before", 64'(busy[0]), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; start[0] = 1'b0;
        #1 chk("flush_idle_after", 64'(busy[0]), 64'd0);
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done[0]) dn++;
        end
        chk("flush_no_done", 64'(dn), 64'd0);

        // Asynchronous reset in the DONE cycle drops the outputs immediately.
        v = vq[10];
        set_ops(v, 4'hA);
        e.sel = 1; e.lo = 32'd42; e.hi = 32'h0; e.hi_en = 1'b0; e.nz_en = 1'b0; e.nz = 4'h0;
        e.clo = 4'hA; e.chi = 4'h5; e.t0 = cyc; e.lat = 2;
        sb.push_back(e);
        start[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done[1]) seen = 1'b1;
        end
        if (!seen) begin
            checks++; fails++;
            $display("FAIL done_timeout: dut1 got no o_done before reset test");
        end
        #2 rst_n = 1'b0; start[1] = 1'b0;
        #1;
        chk("reset_in_done_done", 64'(done[1]), 64'd0);
        chk("reset_in_done_lo", 64'(res_lo[1]), 64'd0);
        chk("reset_in_done_lo_en", 64'(lo_en[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-BUSY abandons the operation.
        set_ops(vq[3], 4'h7);
        start[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0; start[0] = 1'b0;
        #1;
        chk("reset_mid_busy_busy", 64'(busy[0]), 64'd0);
        chk("reset_mid_busy_done", 64'(done[0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        v = vq[0];
        v.rm = 32'h00001234; v.rs = 32'h00000010; v.elo = 32'h00012340;
        issue(v, 4'hC);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
